// File: rtl/lsu_pkg.sv
// lsu_pkg: constants and types shared by the load/store front end.
//   - RV32 funct3 codes for LB/LH/LW/LBU/LHU/SB/SH/SW
//   - FSM state encoding (ST_IDLE / ST_SECOND)
//   - byte-mask width for the two-word window (2*NBYTES) and a size-mask helper
package lsu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NBYTES_DEF = XLEN_DEF / 8;
    localparam int MASK_W     = 2 * NBYTES_DEF;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    // Unshifted byte mask for an access size (funct3[1:0]); code 3 has no size.
    function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return MASK_W'(1);
            2'd1:    return MASK_W'(3);
            2'd2:    return MASK_W'(15);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data alignment.
//   i_window : {high word, low word}; high word is 0 for single-word accesses
//   i_off    : byte offset of the access inside the low word
//   i_funct3 : load size/sign code
//   o_data   : window shifted right by 8*i_off, then sign/zero-extended
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = 2
) (
    input  logic [2*XLEN-1:0] i_window,
    input  logic [OW-1:0]     i_off,
    input  logic [2:0]        i_funct3,
    output logic [XLEN-1:0]   o_data
);

    logic [XLEN-1:0] w_low;

    // Only the low XLEN bits of the shifted window are ever needed.
    assign w_low = XLEN'(i_window >> {i_off, 3'b000});

    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_low[7]}},   w_low[7:0]};
            F3_LH:   o_data = {{(XLEN-16){w_low[15]}}, w_low[15:0]};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}},       w_low[7:0]};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}},      w_low[15:0]};
            // LW passes through; illegal codes are zeroed by the caller.
            default: o_data = w_low;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store front end driving one port of an async-read,
// sync-write, byte-enable data RAM.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : word-crossing accesses take two RAM cycles (IDLE -> SECOND)
//   undefined : word-crossing accesses are rejected with rsp_err, no RAM write
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we, req_funct3   store flag and RV32 size/sign code
//   req_addr, req_wdata  byte address, right-justified store data
//   rsp_valid            one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_err   extended load data / error flag
//   mem_addr, mem_wen    RAM word address and write enable
//   mem_wbe, mem_d       RAM byte enables and lane-shifted write data
//   mem_q                RAM async read data
//   dbg_state            current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_valid may depend on nothing from this block, and the response appears
// as rsp_valid for exactly one cycle, 1 cycle (single word) or 2 cycles
// (split) after the transfer, with no ready from the consumer.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 14,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_wen,
    output logic [NBYTES-1:0] mem_wbe,
    output logic [XLEN-1:0]   mem_d,
    input  logic [XLEN-1:0]   mem_q,
    output lsu_state_e        dbg_state
);

    localparam int MW = 2 * NBYTES;
    localparam int OW = $clog2(NBYTES);

    lsu_state_e        r_state;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;

    logic [OW-1:0]     w_off;
    logic [AWIDTH-1:0] w_idx_a;
    logic [MW-1:0]     w_mask;
    logic              w_cross;
    logic              w_illegal;
    logic              w_err;
    logic              w_accept;
    logic              w_go;
    logic [XLEN-1:0]   w_st_lo;
    logic [2*XLEN-1:0] w_al_window;
    logic [OW-1:0]     w_al_off;
    logic [2:0]        w_al_f3;
    logic [XLEN-1:0]   w_al_data;
    logic              w_unused;

    // Address bits above the RAM word index are intentionally ignored.
    assign w_unused = ^req_addr[31:AWIDTH+OW];

    assign w_off   = req_addr[OW-1:0];
    assign w_idx_a = req_addr[AWIDTH+OW-1:OW];
    // Low half of the mask covers word A, high half covers word A+1.
    assign w_mask  = MW'(size_mask(req_funct3[1:0])) << w_off;
    assign w_cross = |w_mask[MW-1:NBYTES];

    always_comb begin
        w_illegal = 1'b0;
        if (req_we)
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            w_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_err = w_illegal;
`else
    assign w_err = w_illegal | w_cross;
`endif

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid & req_ready;
    // A legal access is being presented to the RAM this cycle (first/only half).
    assign w_go      = w_accept & ~w_err;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2*XLEN-1:0] w_st_window;
    logic              w_in_second;
    logic [AWIDTH-1:0] r_idx_b;
    logic [OW-1:0]     r_off;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [NBYTES-1:0] r_mask_hi;
    logic [XLEN-1:0]   r_d_hi;
    logic [XLEN-1:0]   r_lo;

    assign w_st_window = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};
    assign w_st_lo     = w_st_window[XLEN-1:0];
    assign w_in_second = (r_state == ST_SECOND);
    assign w_al_window = w_in_second ? {mem_q, r_lo} : {{XLEN{1'b0}}, mem_q};
    assign w_al_off    = w_in_second ? r_off : w_off;
    assign w_al_f3     = w_in_second ? r_f3  : req_funct3;
`else
    assign w_st_lo     = req_wdata << {w_off, 3'b000};
    assign w_al_window = {{XLEN{1'b0}}, mem_q};
    assign w_al_off    = w_off;
    assign w_al_f3     = req_funct3;
`endif

    lsu_load_align #(
        .XLEN (XLEN),
        .OW   (OW)
    ) u_align (
        .i_window (w_al_window),
        .i_off    (w_al_off),
        .i_funct3 (w_al_f3),
        .o_data   (w_al_data)
    );

    always_comb begin
        mem_addr = w_idx_a;
        mem_wbe  = w_go ? w_mask[NBYTES-1:0] : '0;
        mem_d    = w_st_lo;
        mem_wen  = w_go & req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (w_in_second) begin
            mem_addr = r_idx_b;
            mem_wbe  = r_mask_hi;
            mem_d    = r_d_hi;
            mem_wen  = r_we;
        end
`endif
        // Reset must stop any write, including an abandoned second half.
        if (!rst_n)
            mem_wen = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (w_go && w_cross) begin
                            r_state   <= ST_SECOND;
                            r_idx_b   <= w_idx_a + AWIDTH'(1);  // wraps to word 0
                            r_off     <= w_off;
                            r_f3      <= req_funct3;
                            r_we      <= req_we;
                            r_mask_hi <= w_mask[MW-1:NBYTES];
                            r_d_hi    <= w_st_window[2*XLEN-1:XLEN];
                            r_lo      <= mem_q;
                        end else
`endif
                        begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= (w_err | req_we) ? '0 : w_al_data;
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_SECOND: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? '0 : w_al_data;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [13:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_d;
    logic [31:0] mem_q;
    lsu_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    lsu_mem_port #(.XLEN(32), .AWIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wbe(mem_wbe),
        .mem_d(mem_d), .mem_q(mem_q), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: async read, byte-enable write on the rising edge
    logic [31:0] ram [0:16383];
    assign mem_q = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_wen)
            for (int b = 0; b < 4; b++)
                if (mem_wbe[b]) ram[mem_addr][8*b +: 8] <= mem_d[8*b +: 8];
    end

    // driver
    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, F3_SW, 32'h10, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", mem_wen); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sw_lw();
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'h10, 32'hDEAD_BEEF);
        #1;
        checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL sw_addr got %h exp 4", mem_addr); end
        checks++; if (mem_wbe !== 4'b1111) begin errors++; $display("FAIL sw_wbe got %b exp 1111", mem_wbe); end
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL sw_wen got %b exp 1", mem_wen); end
        checks++; if (mem_d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_d got %h exp deadbeef", mem_d); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LW, 32'h10, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sw_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL sw_rsp_rdata got %h exp 0", rsp_rdata); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL lw_wen got %b exp 0", mem_wen); end
        checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL lw_addr got %h exp 4", mem_addr); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lw_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rsp_rdata); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_pulse got %b exp 0", rsp_valid); end
    endtask

    // word 4 becomes 0x80ADBEEF
    task automatic test_sb_lb();
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SB, 32'h13, 32'h0000_0080);
        #1;
        checks++; if (mem_wbe !== 4'b1000) begin errors++; $display("FAIL sb_wbe got %b exp 1000", mem_wbe); end
        checks++; if (mem_d !== 32'h8000_0000) begin errors++; $display("FAIL sb_d got %h exp 80000000", mem_d); end
        checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL sb_addr got %h exp 4", mem_addr); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LB, 32'h13, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LBU, 32'h13, 32'h0);
        #1;
        checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rsp_rdata); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LH, 32'h11, 32'h0);
        #1;
        checks++; if (rsp_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", rsp_rdata); end
        checks++; if (mem_wbe !== 4'b0110) begin errors++; $display("FAIL lh_off1_wbe got %b exp 0110", mem_wbe); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LHU, 32'h11, 32'h0);
        #1;
        checks++; if (rsp_rdata !== 32'hFFFF_ADBE) begin errors++; $display("FAIL lh_off1_rdata got %h exp ffffadbe", rsp_rdata); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rsp_rdata !== 32'h0000_ADBE) begin errors++; $display("FAIL lhu_off1_rdata got %h exp 0000adbe", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL lhu_err got %b exp 0", rsp_err); end
    endtask

    task automatic test_cross();
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'h0E, 32'h1122_3344);
        #1;
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (mem_addr !== 14'd3) begin errors++; $display("FAIL x_sw_addr0 got %h exp 3", mem_addr); end
        checks++; if (mem_wbe !== 4'b1100) begin errors++; $display("FAIL x_sw_wbe0 got %b exp 1100", mem_wbe); end
        checks++; if (mem_d !== 32'h3344_0000) begin errors++; $display("FAIL x_sw_d0 got %h exp 33440000", mem_d); end
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL x_sw_wen0 got %b exp 1", mem_wen); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL x_sw_ready got %b exp 0", req_ready); end
        checks++; if (dbg_state !== ST_SECOND) begin errors++; $display("FAIL x_sw_state got %0d exp 1", dbg_state); end
        checks++; if (mem_addr !== 14'd4) begin errors++; $display("FAIL x_sw_addr1 got %h exp 4", mem_addr); end
        checks++; if (mem_wbe !== 4'b0011) begin errors++; $display("FAIL x_sw_wbe1 got %b exp 0011", mem_wbe); end
        checks++; if (mem_d !== 32'h0000_1122) begin errors++; $display("FAIL x_sw_d1 got %h exp 00001122", mem_d); end
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL x_sw_wen1 got %b exp 1", mem_wen); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL x_sw_early_rsp got %b exp 0", rsp_valid); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LW, 32'h0E, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL x_sw_rsp got %b exp 1", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL x_lw_ready0 got %b exp 1", req_ready); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL x_lw_wen got %b exp 0", mem_wen); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL x_lw_ready1 got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL x_lw_early_rsp got %b exp 0", rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL x_lw_rsp got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h1122_3344) begin errors++; $display("FAIL x_lw_rdata got %h exp 11223344", rsp_rdata); end
`else
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL x_sw_wen got %b exp 0", mem_wen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL x_sw_ready got %b exp 1", req_ready); end
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LW, 32'h0E, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL x_sw_rsp got %b exp 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL x_sw_err got %b exp 1", rsp_err); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL x_lw_err got %b exp 1", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL x_lw_rdata got %h exp 0", rsp_rdata); end
`endif
    endtask

    task automatic test_wrap();
        // word 0x3FFF = 0xAB000000, word 0 = 0x000000CD
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'hFFFC, 32'hAB00_0000);
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'h0, 32'h0000_00CD);
        @(negedge clk);
        drive(1'b1, 1'b0, F3_LH, 32'hFFFF, 32'h0);
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL wrap_wen got %b exp 0", mem_wen); end
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (mem_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_addr0 got %h exp 3fff", mem_addr); end
        checks++; if (mem_wbe !== 4'b1000) begin errors++; $display("FAIL wrap_wbe0 got %b exp 1000", mem_wbe); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 0", mem_addr); end
        checks++; if (mem_wbe !== 4'b0001) begin errors++; $display("FAIL wrap_wbe1 got %b exp 0001", mem_wbe); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_rsp got %b exp 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hFFFF_CDAB) begin errors++; $display("FAIL wrap_rdata got %h exp ffffcdab", rsp_rdata); end
`else
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_rsp got %b exp 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL wrap_err got %b exp 1", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wrap_rdata got %h exp 0", rsp_rdata); end
`endif
    endtask

    task automatic test_illegal();
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd3, 32'h20, 32'hFFFF_FFFF);
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL ill_st_wen got %b exp 0", mem_wen); end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd6, 32'h20, 32'h0);
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL ill_st_err got %b exp 1", rsp_err); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_st_rsp got %b exp 1", rsp_valid); end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL ill_ld_err got %b exp 1", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL ill_ld_rdata got %h exp 0", rsp_rdata); end
    endtask

    task automatic test_reset_mid();
`ifdef LSU_MISALIGN_SPLIT_EN
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'h0E, 32'hAABB_CCDD);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rmid_wen got %b exp 0", mem_wen); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmid_state got %0d exp 0", dbg_state); end
        checks++; if (ram[3] !== 32'hCCDD_0000) begin errors++; $display("FAIL rmid_first_half got %h exp ccdd0000", ram[3]); end
        checks++; if (ram[4][15:0] !== 16'h1122) begin errors++; $display("FAIL rmid_second_half got %h exp 1122", ram[4][15:0]); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_late_rsp got %b exp 0", rsp_valid); end
`else
        @(negedge clk);
        drive(1'b1, 1'b1, F3_SW, 32'h30, 32'h1234_5678);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rpulse_rsp got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rpulse_ready got %b exp 1", req_ready); end
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_back_to_back();
        int n_valid;
        logic [31:0] v;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = 32'hA500_0000 + i * 32'h0111_1111;
            drive(1'b1, 1'b1, F3_SW, 32'h100 + 4 * i, v);
        end
        n_valid = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) begin
                drive(1'b1, 1'b0, F3_LW, 32'h100 + 4 * i, 32'h0);
                exp_q.push_back(32'hA500_0000 + i * 32'h0111_1111);
            end else begin
                drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            end
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                if (rsp_valid === 1'b1) n_valid++;
                checks++; if (rsp_rdata !== e) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i - 1, rsp_rdata, e); end
            end
        end
        checks++; if (n_valid !== 8) begin errors++; $display("FAIL b2b_valid_count got %0d exp 8", n_valid); end
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        test_reset();
        test_sw_lw();
        test_sb_lb();
        test_cross();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
